// File: rtl/stack_pkg.sv
// Shared types and helpers for the parametrised LIFO stack.
// Optional feature macro used by the stack files: STACK_HWM_EN (high-water mark).
package stack_pkg;

  typedef enum logic [1:0] {
    CMD_NOP  = 2'b00,
    CMD_PUSH = 2'b01,
    CMD_POP  = 2'b10,
    CMD_GET  = 2'b11
  } cmd_t;

  // Pointer arithmetic modulo depth; caller keeps ptr < depth and k < depth,
  // so a single conditional subtract replaces a true modulo.
  function automatic int unsigned ptr_add(input int unsigned ptr,
                                          input int unsigned k,
                                          input int unsigned depth);
    int unsigned s;
    s = ptr + k;
    if (s >= depth) s = s - depth;
    return s;
  endfunction

endpackage

// File: rtl/stack_ptr_ctl.sv
// Stack pointer/occupancy control: top pointer, COUNT, EMPTY/FULL,
// error pulses and read/write address generation.
// Optional: STACK_HWM_EN adds a high-water-mark register.
module stack_ptr_ctl
  import stack_pkg::*;
#(
  parameter  int unsigned DEPTH = 5,
  parameter  bit          WRAP  = 1'b1,
  localparam int unsigned IW    = $clog2(DEPTH),
  localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  cmd_t          cmd,
  input  logic [IW-1:0] index,
  output logic [IW-1:0] wr_addr,
  output logic          wr_en,
  output logic [IW-1:0] rd_addr,
  output logic          rd_en,
  output logic [CW-1:0] count,
  output logic          empty,
  output logic          full,
  output logic          err_ovf,
  output logic          err_unf,
  output logic          err_idx
`ifdef STACK_HWM_EN
  ,
  output logic [CW-1:0] hwm
`endif
);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam int unsigned   TOP_K   = DEPTH - 1;

  logic [IW-1:0] tp, tp_n;
  logic [CW-1:0] count_n;
  logic          ovf_n, unf_n, idx_n;

  assign wr_addr = tp;
  assign empty   = (count == '0);
  assign full    = (count == DEPTH_C);

  // Decode the command into next pointer/count, memory strobes and error pulses
  always_comb begin
    tp_n    = tp;
    count_n = count;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    rd_addr = '0;
    ovf_n   = 1'b0;
    unf_n   = 1'b0;
    idx_n   = 1'b0;
    case (cmd)
      CMD_PUSH: begin
        if (!full) begin
          wr_en   = 1'b1;
          tp_n    = IW'(ptr_add(32'(tp), 1, DEPTH));
          count_n = count + CW'(1);
        end else begin
          ovf_n = 1'b1;
          if (WRAP) begin
            wr_en = 1'b1;
            tp_n  = IW'(ptr_add(32'(tp), 1, DEPTH));
          end
        end
      end
      CMD_POP: begin
        if (!empty) begin
          rd_en   = 1'b1;
          rd_addr = IW'(ptr_add(32'(tp), TOP_K, DEPTH));
          tp_n    = rd_addr;
          count_n = count - CW'(1);
        end else begin
          unf_n = 1'b1;
        end
      end
      CMD_GET: begin
        // index < count implies index < DEPTH, so TOP_K - index never underflows
        if (32'(index) < 32'(count)) begin
          rd_en   = 1'b1;
          rd_addr = IW'(ptr_add(32'(tp), TOP_K - 32'(index), DEPTH));
        end else begin
          idx_n = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Pointer, occupancy and error-pulse registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tp      <= '0;
      count   <= '0;
      err_ovf <= 1'b0;
      err_unf <= 1'b0;
      err_idx <= 1'b0;
    end else begin
      tp      <= tp_n;
      count   <= count_n;
      err_ovf <= ovf_n;
      err_unf <= unf_n;
      err_idx <= idx_n;
    end
  end

`ifdef STACK_HWM_EN
  // High-water mark tracks the post-edge COUNT; bounded by DEPTH through COUNT
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hwm <= '0;
    end else if (count_n > hwm) begin
      hwm <= count_n;
    end
  end
`endif

endmodule

// File: rtl/stack_param.sv
// Parametrised LIFO stack (WIDTH x DEPTH), circular or saturating when full.
// Holds the storage array and the registered read path.
// Optional: STACK_HWM_EN exposes the HWM high-water-mark port.
module stack_param
  import stack_pkg::*;
#(
  parameter  int unsigned WIDTH = 4,
  parameter  int unsigned DEPTH = 5,
  parameter  bit          WRAP  = 1'b1,
  localparam int unsigned IW    = $clog2(DEPTH),
  localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic [1:0]       COMMAND,
  input  logic [IW-1:0]    INDEX,
  input  logic [WIDTH-1:0] DATA_IN,
  output logic [WIDTH-1:0] DATA_OUT,
  output logic             OUT_VALID,
  output logic [CW-1:0]    COUNT,
  output logic             EMPTY,
  output logic             FULL,
  output logic             ERR_OVF,
  output logic             ERR_UNF,
  output logic             ERR_IDX
`ifdef STACK_HWM_EN
  ,
  output logic [CW-1:0]    HWM
`endif
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [IW-1:0]    wr_addr, rd_addr;
  logic             wr_en, rd_en;

  stack_ptr_ctl #(
    .DEPTH (DEPTH),
    .WRAP  (WRAP)
  ) u_ctl (
    .clk     (CLK),
    .rst_n   (RESET_N),
    .cmd     (cmd_t'(COMMAND)),
    .index   (INDEX),
    .wr_addr (wr_addr),
    .wr_en   (wr_en),
    .rd_addr (rd_addr),
    .rd_en   (rd_en),
    .count   (COUNT),
    .empty   (EMPTY),
    .full    (FULL),
    .err_ovf (ERR_OVF),
    .err_unf (ERR_UNF),
    .err_idx (ERR_IDX)
`ifdef STACK_HWM_EN
    ,
    .hwm     (HWM)
`endif
  );

  // Storage array, cleared on reset
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[wr_addr] <= DATA_IN;
    end
  end

  // Registered read path; DATA_OUT holds whenever no read is performed
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      DATA_OUT  <= '0;
      OUT_VALID <= 1'b0;
    end else begin
      OUT_VALID <= rd_en;
      if (rd_en) DATA_OUT <= mem[rd_addr];
    end
  end

endmodule

// File: tb/tb_stack_param.sv
// Self-checking bench for stack_param: three configurations (5-deep wrap,
// 5-deep saturating, 8-deep wrap) driven by a shared command stream and
// checked against an array-based stack model.
// Define STACK_HWM_EN to also check the HWM port.
module tb_stack_param;

  logic       CLK;
  logic       RESET_N;
  logic [1:0] cmd;
  logic [2:0] idx;
  logic [7:0] din;

  logic [3:0] d0, d1;
  logic [7:0] d2;
  logic       v0, v1, v2;
  logic [2:0] c0, c1;
  logic [3:0] c2;
  logic       e0, e1, e2, f0, f1, f2;
  logic       o0, o1, o2, un0, un1, un2, x0, x1, x2;
`ifdef STACK_HWM_EN
  logic [2:0] h0, h1;
  logic [3:0] h2;
`endif

  int checks = 0;
  int errors = 0;
  bit run_cmp = 1'b0;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  stack_param #(.WIDTH(4), .DEPTH(5), .WRAP(1'b1)) u0 (
    .CLK(CLK), .RESET_N(RESET_N), .COMMAND(cmd), .INDEX(idx), .DATA_IN(din[3:0]),
    .DATA_OUT(d0), .OUT_VALID(v0), .COUNT(c0), .EMPTY(e0), .FULL(f0),
    .ERR_OVF(o0), .ERR_UNF(un0), .ERR_IDX(x0)
`ifdef STACK_HWM_EN
    , .HWM(h0)
`endif
  );

  stack_param #(.WIDTH(4), .DEPTH(5), .WRAP(1'b0)) u1 (
    .CLK(CLK), .RESET_N(RESET_N), .COMMAND(cmd), .INDEX(idx), .DATA_IN(din[3:0]),
    .DATA_OUT(d1), .OUT_VALID(v1), .COUNT(c1), .EMPTY(e1), .FULL(f1),
    .ERR_OVF(o1), .ERR_UNF(un1), .ERR_IDX(x1)
`ifdef STACK_HWM_EN
    , .HWM(h1)
`endif
  );

  stack_param #(.WIDTH(8), .DEPTH(8), .WRAP(1'b1)) u2 (
    .CLK(CLK), .RESET_N(RESET_N), .COMMAND(cmd), .INDEX(idx), .DATA_IN(din),
    .DATA_OUT(d2), .OUT_VALID(v2), .COUNT(c2), .EMPTY(e2), .FULL(f2),
    .ERR_OVF(o2), .ERR_UNF(un2), .ERR_IDX(x2)
`ifdef STACK_HWM_EN
    , .HWM(h2)
`endif
  );

  // Gather DUT outputs into per-configuration arrays
  int a_dout[3], a_valid[3], a_cnt[3], a_empty[3], a_full[3];
  int a_ovf[3], a_unf[3], a_idx[3], a_hwm[3];
  always_comb begin
    a_dout[0] = 32'(d0);  a_dout[1] = 32'(d1);  a_dout[2] = 32'(d2);
    a_valid[0] = 32'(v0); a_valid[1] = 32'(v1); a_valid[2] = 32'(v2);
    a_cnt[0] = 32'(c0);   a_cnt[1] = 32'(c1);   a_cnt[2] = 32'(c2);
    a_empty[0] = 32'(e0); a_empty[1] = 32'(e1); a_empty[2] = 32'(e2);
    a_full[0] = 32'(f0);  a_full[1] = 32'(f1);  a_full[2] = 32'(f2);
    a_ovf[0] = 32'(o0);   a_ovf[1] = 32'(o1);   a_ovf[2] = 32'(o2);
    a_unf[0] = 32'(un0);  a_unf[1] = 32'(un1);  a_unf[2] = 32'(un2);
    a_idx[0] = 32'(x0);   a_idx[1] = 32'(x1);   a_idx[2] = 32'(x2);
`ifdef STACK_HWM_EN
    a_hwm[0] = 32'(h0);   a_hwm[1] = 32'(h1);   a_hwm[2] = 32'(h2);
`else
    a_hwm[0] = 0;         a_hwm[1] = 0;         a_hwm[2] = 0;
`endif
  end

  // Reference model: st[m][0] is the oldest entry, st[m][cnt-1] the top
  int DEP[3] = '{5, 5, 8};
  bit WRP[3] = '{1'b1, 1'b0, 1'b1};
  int MSK[3] = '{15, 15, 255};
  int st[3][8];
  int cnt[3], e_dout[3], e_valid[3], e_ovf[3], e_unf[3], e_idx[3], e_hwm[3];

  always @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int m = 0; m < 3; m++) begin
        cnt[m] = 0; e_dout[m] = 0; e_valid[m] = 0;
        e_ovf[m] = 0; e_unf[m] = 0; e_idx[m] = 0; e_hwm[m] = 0;
      end
    end else begin
      for (int m = 0; m < 3; m++) begin
        e_valid[m] = 0; e_ovf[m] = 0; e_unf[m] = 0; e_idx[m] = 0;
        case (cmd)
          2'b01: begin
            if (cnt[m] < DEP[m]) begin
              st[m][cnt[m]] = int'(din) & MSK[m];
              cnt[m] = cnt[m] + 1;
            end else begin
              e_ovf[m] = 1;
              if (WRP[m]) begin
                for (int k = 0; k < DEP[m] - 1; k++) st[m][k] = st[m][k+1];
                st[m][DEP[m]-1] = int'(din) & MSK[m];
              end
            end
          end
          2'b10: begin
            if (cnt[m] > 0) begin
              cnt[m] = cnt[m] - 1;
              e_dout[m] = st[m][cnt[m]];
              e_valid[m] = 1;
            end else begin
              e_unf[m] = 1;
            end
          end
          2'b11: begin
            if (int'(idx) < cnt[m]) begin
              e_dout[m] = st[m][cnt[m] - 1 - int'(idx)];
              e_valid[m] = 1;
            end else begin
              e_idx[m] = 1;
            end
          end
          default: ;
        endcase
        if (cnt[m] > e_hwm[m]) e_hwm[m] = cnt[m];
      end
    end
  end

  task automatic cmp(input string nm, input int m, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cfg%0d at %0t: got %0d expected %0d", nm, m, $time, act, exp);
    end
  endtask

  // Every-cycle comparison of all three DUTs against the model
  always @(negedge CLK) begin
    if (RESET_N && run_cmp) begin
      for (int m = 0; m < 3; m++) begin
        cmp("dout", m, a_dout[m], e_dout[m]);
        cmp("valid", m, a_valid[m], e_valid[m]);
        cmp("count", m, a_cnt[m], cnt[m]);
        cmp("empty", m, a_empty[m], int'(cnt[m] == 0));
        cmp("full", m, a_full[m], int'(cnt[m] == DEP[m]));
        cmp("err_ovf", m, a_ovf[m], e_ovf[m]);
        cmp("err_unf", m, a_unf[m], e_unf[m]);
        cmp("err_idx", m, a_idx[m], e_idx[m]);
`ifdef STACK_HWM_EN
        cmp("hwm", m, a_hwm[m], e_hwm[m]);
`endif
      end
    end
  end

  task automatic step(input logic [1:0] c, input int i, input int d);
    cmd = c;
    idx = 3'(i);
    din = 8'(d);
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic check_reset_vals(input string tag);
    for (int m = 0; m < 3; m++) begin
      cmp({tag, "_count"}, m, a_cnt[m], 0);
      cmp({tag, "_empty"}, m, a_empty[m], 1);
      cmp({tag, "_full"}, m, a_full[m], 0);
      cmp({tag, "_dout"}, m, a_dout[m], 0);
      cmp({tag, "_valid"}, m, a_valid[m], 0);
`ifdef STACK_HWM_EN
      cmp({tag, "_hwm"}, m, a_hwm[m], 0);
`endif
    end
  endtask

  // Assert reset between clock edges and check outputs clear without a clock
  task automatic mid_reset(input string tag);
    #2 RESET_N = 1'b0;
    #1 check_reset_vals(tag);
    cmd = 2'b00;
    @(negedge CLK);
    #1 RESET_N = 1'b1;
    @(negedge CLK);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    RESET_N = 1'b0;
    cmd = 2'b00; idx = '0; din = '0;
    @(negedge CLK); @(negedge CLK);
    check_reset_vals("por");
    #1 RESET_N = 1'b1;
    @(negedge CLK);
    run_cmp = 1'b1;

    // Basic push/get/pop
    step(2'b01, 0, 1); step(2'b01, 0, 2); step(2'b01, 0, 3);
    step(2'b11, 0, 0);
    cmp("get0", 0, a_dout[0], 3); cmp("get0_valid", 0, a_valid[0], 1);
    step(2'b11, 2, 0);
    cmp("get2", 0, a_dout[0], 1);
    step(2'b10, 0, 0);
    cmp("pop3", 0, a_dout[0], 3); cmp("pop3_count", 0, a_cnt[0], 2);
    step(2'b11, 3, 0);
    cmp("getbad_err", 0, a_idx[0], 1); cmp("getbad_valid", 0, a_valid[0], 0);
    cmp("getbad_hold", 0, a_dout[0], 3);
    step(2'b11, 1, 0);
    cmp("get1", 0, a_dout[0], 1);
    step(2'b10, 0, 0); step(2'b10, 0, 0);
    cmp("drained", 0, a_empty[0], 1);

    // Overflow: wrap vs saturate
    for (int v = 1; v <= 6; v++) step(2'b01, 0, v);
    cmp("ovf_w", 0, a_ovf[0], 1); cmp("ovf_w_cnt", 0, a_cnt[0], 5);
    cmp("ovf_w_full", 0, a_full[0], 1);
    cmp("ovf_s", 1, a_ovf[1], 1); cmp("ovf_s_cnt", 1, a_cnt[1], 5);
    cmp("noovf8", 2, a_ovf[2], 0); cmp("noovf8_cnt", 2, a_cnt[2], 6);
    for (int p = 0; p < 5; p++) begin
      step(2'b10, 0, 0);
      cmp("popw", 0, a_dout[0], 6 - p);
      cmp("pops", 1, a_dout[1], 5 - p);
    end
    step(2'b10, 0, 0);
    cmp("unf_w", 0, a_unf[0], 1); cmp("unf_w_hold", 0, a_dout[0], 2);
    cmp("unf_s", 1, a_unf[1], 1); cmp("unf_s_hold", 1, a_dout[1], 1);
    cmp("pop8", 2, a_dout[2], 1);
    step(2'b10, 0, 0);
    cmp("unf8", 2, a_unf[2], 1);

    // Randomised phase with varying push bias
    for (int b = 0; b < 40; b++) begin
      int w;
      w = int'($urandom_range(15, 85));
      if (b == 20) mid_reset("rnd_rst");
      for (int n = 0; n < 100; n++) begin
        int r;
        r = int'($urandom_range(0, 99));
        if (r < w) step(2'b01, 0, int'($urandom_range(0, 255)));
        else step(2'(1 + $urandom_range(0, 2)), int'($urandom_range(0, 7)),
                  int'($urandom_range(0, 255)));
      end
    end

    // High-water mark sequence and reset behaviour
    mid_reset("hwm_rst0");
    for (int k = 0; k < 4; k++) step(2'b01, 0, k + 7);
    for (int k = 0; k < 3; k++) step(2'b10, 0, 0);
    step(2'b01, 0, 9);
`ifdef STACK_HWM_EN
    cmp("hwm4", 0, a_hwm[0], 4);
`endif
    cmp("cnt2", 0, a_cnt[0], 2);
    mid_reset("hwm_rst1");
    step(2'b10, 0, 0);
    cmp("unf_after_rst", 0, a_unf[0], 1);
    cmp("unf_after_rst_dout", 0, a_dout[0], 0);

    step(2'b00, 0, 0);
    run_cmp = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
